pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-low reset; all flops on rising clk.
REQ-002 SHALL have inputs: imem_req 1 (IF fetching); imem_resp 1 (fetch data valid this cycle); dmem_req 1 (EX/MEM holds load/store); dmem_resp 1 (data access done this cycle).
REQ-003 SHALL have inputs: idex_mem_read 1; idex_rd 5; ifid_rs1 5; ifid_rs2 5; ifid_rs1_used 1; ifid_rs2_used 1.
REQ-004 SHALL have inputs: br_taken 1 (taken branch/jump resolved in EX/MEM); br_target 32 (its target PC).
REQ-005 SHALL have outputs: pc_load, ifid_load, idex_load, exmem_load, memwb_load (1 each, stage register load); ifid_flush, idex_flush, exmem_flush, memwb_flush (1 each, active-high synchronous clear to the stage register).
REQ-006 SHALL have outputs: pc_sel_redirect 1 (PC mux selects pc_redirect); pc_redirect 32; state 2; stall_cycles 32; flush_count 16.

Function
REQ-007 SHALL define dstall = dmem_req & ~dmem_resp; istall = imem_req & ~imem_resp; luh = idex_mem_read & idex_rd!=0 & ((ifid_rs1_used & idex_rd==ifid_rs1) | (ifid_rs2_used & idex_rd==ifid_rs2)).
REQ-008 SHALL implement states RUN=0, FLUSH_WAIT=1, DSTALL=2; state output mirrors register.
REQ-009 Default (RUN, no event): all loads 1, all flushes 0, pc_sel_redirect 0.
REQ-010 Priority per cycle SHALL be: dstall > br_taken > luh > istall.
REQ-011 dstall: all five loads 0, all flushes 0 (whole pipe frozen); br_taken ignored that cycle; next state DSTALL; DSTALL -> RUN in cycle dmem_resp=1, with default outputs that cycle.
REQ-012 br_taken, no istall: pc_load 1, pc_sel_redirect 1, pc_redirect=br_target, ifid_flush=idex_flush=exmem_flush=1, memwb_load 1; state stays RUN.
REQ-013 br_taken with istall: latch br_target into redirect register; ifid/idex/exmem flushes 1; pc_load 0; next state FLUSH_WAIT.
REQ-014 FLUSH_WAIT: pc_load 0, ifid_flush 1, other loads 1, further br_taken ignored; on imem_resp=1: pc_load 1, pc_sel_redirect 1, pc_redirect=latched target, ifid_flush 1 (discard stale fetch), next state RUN.
REQ-015 luh (no dstall/br_taken): pc_load 0, ifid_load 0, idex_flush 1, exmem/memwb loads 1; exactly one bubble per hazard.
REQ-016 istall only (RUN): pc_load 0, ifid_load 0, ifid_flush 1, downstream loads 1 (older instructions drain).
REQ-017 pc_redirect SHALL equal br_target combinationally in RUN and the latched register in FLUSH_WAIT.
REQ-018 stall_cycles SHALL increment by 1 each cycle pc_load=0, saturating at 0xFFFFFFFF.
REQ-019 flush_count SHALL increment once per accepted br_taken (REQ-012/013 only), saturating at 0xFFFF.
REQ-020 All outputs other than state, counters and redirect register SHALL be combinational from inputs and state.

Reset
REQ-021 rst=0 SHALL asynchronously force state RUN, redirect register 0, stall_cycles 0, flush_count 0.
REQ-022 While rst=0 SHALL drive all loads 0, all flushes 1, pc_sel_redirect 0.
REQ-023 Reset mid-DSTALL or mid-FLUSH_WAIT SHALL discard pending stall/redirect; first cycle after rst=1 behaves as RUN.

Verification
REQ-024 dmem_req=1, dmem_resp=0 three cycles then 1 -> loads 0 for 3 cycles, state=2, stall_cycles=3, then all loads 1, state=0.
REQ-025 idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_rs2_used=1 -> one cycle pc_load=0, ifid_load=0, idex_flush=1; idex_rd=0 same case -> no bubble.
REQ-026 br_taken=1, br_target=0x00000080, imem_resp=1 -> pc_sel_redirect=1, pc_redirect=0x80, ifid/idex/exmem flush=1, flush_count=1.
REQ-027 br_taken=1, br_target=0x40, imem_req=1, imem_resp=0 two cycles then 1 -> state=1, pc_load=0 for 2 cycles, then pc_redirect=0x40 with pc_sel_redirect=1 and ifid_flush=1, state=0.
REQ-028 dmem stall coincident with br_taken=1 -> freeze, flush_count unchanged; assert rst=0 in FLUSH_WAIT -> state=0, counters 0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Pipeline hazard/stall controller bundle.
// Slave side is the controller, master side the datapath.
interface pipeline_ctrl_if;
    logic        imem_req;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_rs1_used;
    logic        ifid_rs2_used;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pc_load;
    logic        ifid_load;
    logic        idex_load;
    logic        exmem_load;
    logic        memwb_load;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        pc_sel_redirect;
    logic [31:0] pc_redirect;
    logic [1:0]  state;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    modport master (
        output imem_req, imem_resp, dmem_req, dmem_resp,
        output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2,
        output ifid_rs1_used, ifid_rs2_used, br_taken, br_target,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  pc_sel_redirect, pc_redirect, state,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  imem_req, imem_resp, dmem_req, dmem_resp,
        input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2,
        input  ifid_rs1_used, ifid_rs2_used, br_taken, br_target,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output pc_sel_redirect, pc_redirect, state,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stalls, bubbles, redirects.
// Priority: data stall > branch > load-use > fetch stall.
module pipeline_ctrl (
    input  logic clk,
    input  logic rst,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        DSTALL     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] redirect_q;
    logic [31:0] stall_q;
    logic [15:0] fcnt_q;
    logic        latch_tgt, take_br;
    logic        dstall, istall, luh;
    logic        pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
    logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
    logic        sel;

    assign dstall = bus.dmem_req & ~bus.dmem_resp;
    assign istall = bus.imem_req & ~bus.imem_resp;
    assign luh = bus.idex_mem_read && bus.idex_rd != 5'd0 &&
                 ((bus.ifid_rs1_used && bus.idex_rd == bus.ifid_rs1) ||
                  (bus.ifid_rs2_used && bus.idex_rd == bus.ifid_rs2));

    // Next state and per-stage load/flush decode
    always_comb begin
        state_d   = state_q;
        latch_tgt = 1'b0;
        take_br   = 1'b0;
        pc_ld     = 1'b1;
        ifid_ld   = 1'b1;
        idex_ld   = 1'b1;
        exmem_ld  = 1'b1;
        memwb_ld  = 1'b1;
        ifid_fl   = 1'b0;
        idex_fl   = 1'b0;
        exmem_fl  = 1'b0;
        memwb_fl  = 1'b0;
        sel       = 1'b0;
        if (!rst) begin
            pc_ld    = 1'b0;
            ifid_ld  = 1'b0;
            idex_ld  = 1'b0;
            exmem_ld = 1'b0;
            memwb_ld = 1'b0;
            ifid_fl  = 1'b1;
            idex_fl  = 1'b1;
            exmem_fl = 1'b1;
            memwb_fl = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dstall) begin
                        pc_ld    = 1'b0;
                        ifid_ld  = 1'b0;
                        idex_ld  = 1'b0;
                        exmem_ld = 1'b0;
                        memwb_ld = 1'b0;
                        state_d  = DSTALL;
                    end else if (bus.br_taken) begin
                        take_br  = 1'b1;
                        ifid_fl  = 1'b1;
                        idex_fl  = 1'b1;
                        exmem_fl = 1'b1;
                        if (istall) begin
                            // Fetch busy: park the target until it returns
                            pc_ld     = 1'b0;
                            latch_tgt = 1'b1;
                            state_d   = FLUSH_WAIT;
                        end else begin
                            sel = 1'b1;
                        end
                    end else if (luh) begin
                        pc_ld   = 1'b0;
                        ifid_ld = 1'b0;
                        idex_fl = 1'b1;
                    end else if (istall) begin
                        pc_ld   = 1'b0;
                        ifid_ld = 1'b0;
                        ifid_fl = 1'b1;
                    end
                end
                FLUSH_WAIT: begin
                    // Outstanding fetch is stale whenever it lands
                    ifid_fl = 1'b1;
                    if (bus.imem_resp) begin
                        sel     = 1'b1;
                        state_d = RUN;
                    end else begin
                        pc_ld = 1'b0;
                    end
                end
                DSTALL: begin
                    if (bus.dmem_resp) begin
                        state_d = RUN;
                    end else begin
                        pc_ld    = 1'b0;
                        ifid_ld  = 1'b0;
                        idex_ld  = 1'b0;
                        exmem_ld = 1'b0;
                        memwb_ld = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, parked redirect target and saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            redirect_q <= 32'd0;
            stall_q    <= 32'd0;
            fcnt_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            if (latch_tgt)
                redirect_q <= bus.br_target;
            if (!pc_ld && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            if (take_br && fcnt_q != 16'hFFFF)
                fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign bus.pc_load         = pc_ld;
    assign bus.ifid_load       = ifid_ld;
    assign bus.idex_load       = idex_ld;
    assign bus.exmem_load      = exmem_ld;
    assign bus.memwb_load      = memwb_ld;
    assign bus.ifid_flush      = ifid_fl;
    assign bus.idex_flush      = idex_fl;
    assign bus.exmem_flush     = exmem_fl;
    assign bus.memwb_flush     = memwb_fl;
    assign bus.pc_sel_redirect = sel;
    assign bus.pc_redirect     = (state_q == FLUSH_WAIT) ? redirect_q
                                                         : bus.br_target;
    assign bus.state           = state_q;
    assign bus.stall_cycles    = stall_q;
    assign bus.flush_count     = fcnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl.
// Vector table for single-cycle decode, sequences for multi-cycle cases.
module tb_pipeline_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus ();
    pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [15:0] exp_fc    = 16'd0;

    typedef struct {
        logic        ireq, iresp, dreq, dresp, mr;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, br;
        logic [31:0] tgt;
        logic [4:0]  ld;
        logic [3:0]  fl;
        logic        sel;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] loads();
        return {bus.pc_load, bus.ifid_load, bus.idex_load,
                bus.exmem_load, bus.memwb_load};
    endfunction

    function automatic logic [3:0] flushes();
        return {bus.ifid_flush, bus.idex_flush,
                bus.exmem_flush, bus.memwb_flush};
    endfunction

    task automatic idle();
        bus.imem_req      = 1'b0;
        bus.imem_resp     = 1'b0;
        bus.dmem_req      = 1'b0;
        bus.dmem_resp     = 1'b0;
        bus.idex_mem_read = 1'b0;
        bus.idex_rd       = 5'd0;
        bus.ifid_rs1      = 5'd0;
        bus.ifid_rs2      = 5'd0;
        bus.ifid_rs1_used = 1'b0;
        bus.ifid_rs2_used = 1'b0;
        bus.br_taken      = 1'b0;
        bus.br_target     = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_stall"}, bus.stall_cycles, exp_stall);
        chk({tag, "_fcnt"}, bus.flush_count, exp_fc);
    endtask

    initial begin
        //            ireq iresp dreq dresp mr rd rs1 rs2 u1 u2 br tgt  ld fl sel
        vecs[0]  = '{0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 32'h0,   5'b11111,4'b0000,0};
        vecs[1]  = '{0,0,0,0,1, 5'd5,5'd0,5'd5, 0,1,0, 32'h0,   5'b00111,4'b0100,0};
        vecs[2]  = '{0,0,0,0,1, 5'd0,5'd0,5'd0, 0,1,0, 32'h0,   5'b11111,4'b0000,0};
        vecs[3]  = '{0,0,0,0,1, 5'd7,5'd7,5'd0, 0,0,0, 32'h0,   5'b11111,4'b0000,0};
        vecs[4]  = '{0,0,0,0,1, 5'd7,5'd7,5'd0, 1,0,0, 32'h0,   5'b00111,4'b0100,0};
        vecs[5]  = '{1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 32'h0,   5'b00111,4'b1000,0};
        vecs[6]  = '{1,0,0,0,1, 5'd3,5'd3,5'd0, 1,0,0, 32'h0,   5'b00111,4'b0100,0};
        vecs[7]  = '{1,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, 32'h80,  5'b11111,4'b1110,1};
        vecs[8]  = '{0,0,0,0,1, 5'd9,5'd9,5'd0, 1,0,1, 32'h100, 5'b11111,4'b1110,1};
        vecs[9]  = '{0,0,0,0,0, 5'd4,5'd4,5'd4, 1,1,0, 32'h0,   5'b11111,4'b0000,0};
        vecs[10] = '{0,0,1,1,0, 5'd0,5'd0,5'd0, 0,0,0, 32'h0,   5'b11111,4'b0000,0};

        idle();
        #1;
        chk("rst_state", bus.state, 2'd0);
        chk("rst_loads", loads(), 5'b00000);
        chk("rst_flush", flushes(), 4'b1111);
        chk("rst_sel", bus.pc_sel_redirect, 1'b0);
        chk_cnt("rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_loads", loads(), 5'b11111);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            bus.imem_req      = vecs[i].ireq;
            bus.imem_resp     = vecs[i].iresp;
            bus.dmem_req      = vecs[i].dreq;
            bus.dmem_resp     = vecs[i].dresp;
            bus.idex_mem_read = vecs[i].mr;
            bus.idex_rd       = vecs[i].rd;
            bus.ifid_rs1      = vecs[i].rs1;
            bus.ifid_rs2      = vecs[i].rs2;
            bus.ifid_rs1_used = vecs[i].u1;
            bus.ifid_rs2_used = vecs[i].u2;
            bus.br_taken      = vecs[i].br;
            bus.br_target     = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_loads", i), loads(), vecs[i].ld);
            chk($sformatf("v%0d_flush", i), flushes(), vecs[i].fl);
            chk($sformatf("v%0d_sel", i), bus.pc_sel_redirect, vecs[i].sel);
            chk($sformatf("v%0d_redir", i), bus.pc_redirect, vecs[i].tgt);
            if (!vecs[i].ld[4]) exp_stall = exp_stall + 32'd1;
            if (vecs[i].br) exp_fc = exp_fc + 16'd1;
            cyc();
            chk($sformatf("v%0d_state", i), bus.state, 2'd0);
            chk_cnt($sformatf("v%0d", i));
        end

        // Data stall for three cycles; a branch on the first is ignored
        idle();
        bus.dmem_req  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ds%0d_loads", i), loads(), 5'b00000);
            chk($sformatf("ds%0d_flush", i), flushes(), 4'b0000);
            chk($sformatf("ds%0d_sel", i), bus.pc_sel_redirect, 1'b0);
            exp_stall = exp_stall + 32'd1;
            cyc();
            bus.br_taken = 1'b0;
            chk($sformatf("ds%0d_state", i), bus.state, 2'd2);
        end
        bus.dmem_resp = 1'b1;
        #1;
        chk("ds_done_loads", loads(), 5'b11111);
        chk("ds_done_flush", flushes(), 4'b0000);
        cyc();
        chk("ds_done_state", bus.state, 2'd0);
        chk_cnt("ds_done");

        // Branch during fetch stall, two waits, then redirect
        idle();
        bus.imem_req  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h40;
        #1;
        chk("fw_enter_loads", loads(), 5'b01111);
        chk("fw_enter_flush", flushes(), 4'b1110);
        chk("fw_enter_sel", bus.pc_sel_redirect, 1'b0);
        exp_stall = exp_stall + 32'd1;
        exp_fc    = exp_fc + 16'd1;
        cyc();
        chk("fw_state", bus.state, 2'd1);
        bus.br_target = 32'h99;
        #1;
        chk("fw_wait_loads", loads(), 5'b01111);
        chk("fw_wait_flush", flushes(), 4'b1000);
        chk("fw_wait_redir", bus.pc_redirect, 32'h40);
        exp_stall = exp_stall + 32'd1;
        cyc();
        chk("fw_state2", bus.state, 2'd1);
        bus.imem_resp = 1'b1;
        #1;
        chk("fw_resp_loads", loads(), 5'b11111);
        chk("fw_resp_flush", flushes(), 4'b1000);
        chk("fw_resp_sel", bus.pc_sel_redirect, 1'b1);
        chk("fw_resp_redir", bus.pc_redirect, 32'h40);
        cyc();
        chk("fw_exit_state", bus.state, 2'd0);
        chk_cnt("fw_exit");

        // Reset while parked in FLUSH_WAIT
        idle();
        bus.imem_req  = 1'b1;
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h300;
        cyc();
        chk("rfw_state", bus.state, 2'd1);
        rst = 1'b0;
        #1;
        chk("rfw_state0", bus.state, 2'd0);
        chk("rfw_stall0", bus.stall_cycles, 32'd0);
        chk("rfw_fcnt0", bus.flush_count, 16'd0);
        chk("rfw_loads", loads(), 5'b00000);
        chk("rfw_flush", flushes(), 4'b1111);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rfw_run_loads", loads(), 5'b11111);
        chk("rfw_run_redir", bus.pc_redirect, 32'h0);
        exp_stall = 32'd0;
        exp_fc    = 16'd0;

        // Reset while frozen in DSTALL
        @(negedge clk);
        bus.dmem_req = 1'b1;
        exp_stall = exp_stall + 32'd1;
        cyc();
        chk("rds_state", bus.state, 2'd2);
        chk_cnt("rds");
        rst = 1'b0;
        #1;
        chk("rds_state0", bus.state, 2'd0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rds_run_loads", loads(), 5'b11111);
        cyc();
        chk("rds_run_state", bus.state, 2'd0);
        chk("rds_run_stall", bus.stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
